// File: rtl/fetch_mem_unit.sv
// Instruction fetch / data memory unit: PC, IR, MDR and a single-port word memory behind a 4-state FSM.
// Optional FMU_FAULT_EN: out-of-range addresses skip the memory, read as 0 and raise a sticky fault.
module fetch_mem_unit #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int MEM_AW = 10,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              fetch_req,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              pc_write,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              is_branch,
  input  logic [1:0]        branch_type,
  input  logic              zero,
  input  logic              negative,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ir,
  output logic [6:0]        ir_op,
  output logic [2:0]        ir_ra,
  output logic [2:0]        ir_rb,
  output logic [2:0]        ir_rd,
  output logic [DATA_W-1:0] ir_imm,
  output logic [DATA_W-1:0] mdr,
  output logic              busy,
  output logic              fetch_done,
  output logic              mem_done,
  output logic              fault
);

  typedef enum logic [1:0] {IDLE, FETCH, MREAD, MWRITE} state_t;

  state_t              state, state_nx;
  logic                acc_fetch, acc_rd, acc_wr, pc_load, br_cond;
  logic [ADDR_W-1:0]   acc_addr;
  logic [MEM_AW-1:0]   acc_idx;
  logic                oob, mem_en;
  logic [DATA_W-1:0]   mem [0:(1<<MEM_AW)-1];
  logic [DATA_W-1:0]   rd_data_p1;
  logic                acc_oob_p1;

  always_comb begin
    case (branch_type)
      2'b00:   br_cond = 1'b1;
      2'b01:   br_cond = zero;
      2'b10:   br_cond = !zero;
      default: br_cond = negative;
    endcase
  end

  // Request arbitration: only IDLE accepts; mem_req > pc_write > fetch_req, losers are dropped.
  always_comb begin
    state_nx  = state;
    acc_fetch = 1'b0;
    acc_rd    = 1'b0;
    acc_wr    = 1'b0;
    pc_load   = 1'b0;
    case (state)
      IDLE: begin
        if (RST) begin
          state_nx = IDLE;
        end else if (mem_req) begin
          acc_wr   = mem_we;
          acc_rd   = !mem_we;
          state_nx = mem_we ? MWRITE : MREAD;
        end else if (pc_write) begin
          pc_load = !is_branch || br_cond;
        end else if (fetch_req) begin
          acc_fetch = 1'b1;
          state_nx  = FETCH;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign acc_addr = acc_fetch ? pc : mem_addr;
  assign acc_idx  = acc_addr[MEM_AW-1:0];

`ifdef FMU_FAULT_EN
  assign oob = |(acc_addr >> MEM_AW);
`else
  logic unused_hi;
  assign unused_hi = |(acc_addr >> MEM_AW);
  assign oob       = 1'b0;
`endif

  assign mem_en = (acc_fetch || acc_rd || acc_wr) && !oob;

  // Stage p0 -> p1: memory access at the accepting edge; storage is never reset.
  always_ff @(posedge CLK) begin
    if (mem_en && acc_wr)
      mem[acc_idx] <= mem_wdata;
    if (mem_en)
      rd_data_p1 <= mem[acc_idx];
  end

  // Stage p1 -> architectural registers: completion edge loads IR/MDR and pulses done.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      ir         <= '0;
      mdr        <= '0;
      fetch_done <= 1'b0;
      mem_done   <= 1'b0;
      acc_oob_p1 <= 1'b0;
    end else begin
      state      <= state_nx;
      fetch_done <= 1'b0;
      mem_done   <= 1'b0;
      if (pc_load)
        pc <= new_pc;
      if (acc_fetch || acc_rd || acc_wr)
        acc_oob_p1 <= oob;
      case (state)
        FETCH: begin
          ir         <= acc_oob_p1 ? '0 : rd_data_p1;
          pc         <= pc + ADDR_W'(1);
          fetch_done <= 1'b1;
        end
        MREAD: begin
          mdr      <= acc_oob_p1 ? '0 : rd_data_p1;
          mem_done <= 1'b1;
        end
        MWRITE: mem_done <= 1'b1;
        default: ;
      endcase
    end
  end

`ifdef FMU_FAULT_EN
  logic fault_q;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      fault_q <= 1'b0;
    else if ((acc_fetch || acc_rd || acc_wr) && oob)
      fault_q <= 1'b1;
  end
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  assign busy   = (state != IDLE);
  assign ir_op  = ir[15:9];
  assign ir_ra  = ir[8:6];
  assign ir_rb  = ir[5:3];
  assign ir_rd  = ir[2:0];
  assign ir_imm = {{(DATA_W-6){ir[5]}}, ir[5:0]};

endmodule

// File: tb/tb_fetch_mem_unit.sv
// Directed self-checking bench for fetch_mem_unit (default parameters; fault expectations follow FMU_FAULT_EN).
module tb_fetch_mem_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        fetch_req = 1'b0, mem_req = 1'b0, mem_we = 1'b0;
  logic [15:0] mem_addr = '0, mem_wdata = '0, new_pc = '0;
  logic        pc_write = 1'b0, is_branch = 1'b0, zero = 1'b0, negative = 1'b0;
  logic [1:0]  branch_type = 2'b00;
  logic [15:0] pc, ir, ir_imm, mdr;
  logic [6:0]  ir_op;
  logic [2:0]  ir_ra, ir_rb, ir_rd;
  logic        busy, fetch_done, mem_done, fault;

  int checks = 0;
  int failures = 0;

  fetch_mem_unit #(.DATA_W(16), .ADDR_W(16), .MEM_AW(10), .RESET_PC(16'h0000)) dut (
    .CLK(CLK), .RST(RST), .fetch_req(fetch_req), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .pc_write(pc_write), .new_pc(new_pc),
    .is_branch(is_branch), .branch_type(branch_type), .zero(zero), .negative(negative),
    .pc(pc), .ir(ir), .ir_op(ir_op), .ir_ra(ir_ra), .ir_rb(ir_rb), .ir_rd(ir_rd),
    .ir_imm(ir_imm), .mdr(mdr), .busy(busy), .fetch_done(fetch_done), .mem_done(mem_done),
    .fault(fault)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d);
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = a; mem_wdata = d;
    step();
    mem_req = 1'b0; mem_we = 1'b0;
    step();
  endtask

  task automatic do_read(input logic [15:0] a);
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = a;
    step();
    mem_req = 1'b0;
    step();
  endtask

  task automatic test_reset();
    #2 RST = 1'b1;
    #1;
    checks++; if (pc !== 16'h0000) begin failures++; $display("FAIL reset_pc actual=%h required=0000", pc); end
    checks++; if (ir !== 16'h0000 || mdr !== 16'h0000) begin failures++; $display("FAIL reset_ir_mdr actual=%h/%h required=0000/0000", ir, mdr); end
    checks++; if ({busy, fetch_done, mem_done, fault} !== 4'b0000) begin failures++; $display("FAIL reset_flags actual=%b required=0000", {busy, fetch_done, mem_done, fault}); end
    step(); step();
    RST = 1'b0;
    step();
  endtask

  task automatic test_fetch();
    do_write(16'd0, 16'h1234);
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    checks++; if (busy !== 1'b1 || fetch_done !== 1'b0) begin failures++; $display("FAIL fetch_busy actual=%b%b required=10", busy, fetch_done); end
    step();
    checks++; if (pc !== 16'h0001) begin failures++; $display("FAIL fetch_pc actual=%h required=0001", pc); end
    checks++; if (ir !== 16'h1234) begin failures++; $display("FAIL fetch_ir actual=%h required=1234", ir); end
    checks++; if ({ir_op, ir_ra, ir_rb, ir_rd} !== {7'h09, 3'd0, 3'd6, 3'd4}) begin failures++; $display("FAIL fetch_fields actual=%h/%0d/%0d/%0d required=09/0/6/4", ir_op, ir_ra, ir_rb, ir_rd); end
    checks++; if (ir_imm !== 16'hFFF4) begin failures++; $display("FAIL fetch_imm actual=%h required=fff4", ir_imm); end
    checks++; if (fetch_done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL fetch_done actual=%b%b required=10", fetch_done, busy); end
    step();
    checks++; if (fetch_done !== 1'b0) begin failures++; $display("FAIL fetch_pulse actual=%b required=0", fetch_done); end
  endtask

  task automatic test_back_to_back();
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 16'd5; mem_wdata = 16'hBEEF;
    step();
    mem_we = 1'b0;
    checks++; if (busy !== 1'b1 || mem_done !== 1'b0) begin failures++; $display("FAIL wr_busy actual=%b%b required=10", busy, mem_done); end
    step();
    checks++; if (busy !== 1'b0 || mem_done !== 1'b1) begin failures++; $display("FAIL wr_done actual=%b%b required=01", busy, mem_done); end
    checks++; if (mdr !== 16'h0000) begin failures++; $display("FAIL wr_mdr_kept actual=%h required=0000", mdr); end
    step();
    mem_req = 1'b0;
    checks++; if (busy !== 1'b1 || mem_done !== 1'b0) begin failures++; $display("FAIL rd_busy actual=%b%b required=10", busy, mem_done); end
    step();
    checks++; if (busy !== 1'b0 || mem_done !== 1'b1) begin failures++; $display("FAIL rd_done actual=%b%b required=01", busy, mem_done); end
    checks++; if (mdr !== 16'hBEEF) begin failures++; $display("FAIL rd_mdr actual=%h required=beef", mdr); end
  endtask

  task automatic test_priority();
    do_write(16'd5, 16'h5A5A);
    fetch_req = 1'b1; mem_req = 1'b1; mem_we = 1'b0; mem_addr = 16'd5;
    pc_write = 1'b1; is_branch = 1'b0; new_pc = 16'd40;
    step();
    fetch_req = 1'b0; mem_req = 1'b0; pc_write = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL prio_busy actual=%b required=1", busy); end
    step();
    checks++; if (mem_done !== 1'b1 || fetch_done !== 1'b0 || mdr !== 16'h5A5A) begin failures++; $display("FAIL prio_read actual=%b%b/%h required=10/5a5a", mem_done, fetch_done, mdr); end
    checks++; if (pc !== 16'h0001 || ir !== 16'h1234) begin failures++; $display("FAIL prio_pc_ir actual=%h/%h required=0001/1234", pc, ir); end
    step();
    checks++; if (busy !== 1'b0 || pc !== 16'h0001) begin failures++; $display("FAIL prio_noqueue actual=%b/%h required=0/0001", busy, pc); end
  endtask

  task automatic test_branch();
    pc_write = 1'b1; is_branch = 1'b1; branch_type = 2'b01; zero = 1'b0; negative = 1'b0; new_pc = 16'd40;
    step();
    checks++; if (pc !== 16'd1 || busy !== 1'b0) begin failures++; $display("FAIL br_z_not_taken actual=%h required=0001", pc); end
    zero = 1'b1;
    step();
    checks++; if (pc !== 16'd40) begin failures++; $display("FAIL br_z_taken actual=%h required=0028", pc); end
    branch_type = 2'b10; new_pc = 16'd50;
    step();
    checks++; if (pc !== 16'd40) begin failures++; $display("FAIL br_nz_not_taken actual=%h required=0028", pc); end
    branch_type = 2'b11; negative = 1'b1; new_pc = 16'd100;
    step();
    checks++; if (pc !== 16'd100) begin failures++; $display("FAIL br_neg_taken actual=%h required=0064", pc); end
    is_branch = 1'b0; negative = 1'b0; zero = 1'b0; new_pc = 16'd7;
    step();
    checks++; if (pc !== 16'd7) begin failures++; $display("FAIL pc_write actual=%h required=0007", pc); end
    pc_write = 1'b0;
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0; pc_write = 1'b1; new_pc = 16'd200;
    step();
    pc_write = 1'b0;
    checks++; if (pc !== 16'd8 || fetch_done !== 1'b1) begin failures++; $display("FAIL pc_write_busy actual=%h/%b required=0008/1", pc, fetch_done); end
    step();
  endtask

  task automatic test_reset_mid();
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_mid_busy actual=%b required=1", busy); end
    RST = 1'b1;
    #1;
    checks++; if (pc !== 16'h0000 || busy !== 1'b0 || ir !== 16'h0000) begin failures++; $display("FAIL rst_mid_async actual=%h/%b/%h required=0000/0/0000", pc, busy, ir); end
    step();
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (fetch_done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rst_mid_no_done actual=%b%b required=00", fetch_done, busy); end
    end
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 16'd9; mem_wdata = 16'h0909;
    step();
    mem_req = 1'b0; mem_we = 1'b0;
    RST = 1'b1;
    #1;
    step();
    RST = 1'b0;
    step();
    checks++; if (mem_done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rst_wr_no_done actual=%b%b required=00", mem_done, busy); end
    do_read(16'd9);
    checks++; if (mdr !== 16'h0909) begin failures++; $display("FAIL rst_wr_committed actual=%h required=0909", mdr); end
    do_read(16'd5);
    checks++; if (mdr !== 16'h5A5A) begin failures++; $display("FAIL mem_survives_rst actual=%h required=5a5a", mdr); end
  endtask

  task automatic test_fault();
    do_read(16'h0400);
    checks++; if (mem_done !== 1'b1) begin failures++; $display("FAIL oob_done actual=%b required=1", mem_done); end
`ifdef FMU_FAULT_EN
    checks++; if (mdr !== 16'h0000 || fault !== 1'b1) begin failures++; $display("FAIL oob_fault actual=%h/%b required=0000/1", mdr, fault); end
    do_read(16'd5);
    checks++; if (fault !== 1'b1 || mdr !== 16'h5A5A) begin failures++; $display("FAIL fault_sticky actual=%b/%h required=1/5a5a", fault, mdr); end
`else
    checks++; if (mdr !== 16'h1234 || fault !== 1'b0) begin failures++; $display("FAIL oob_wrap actual=%h/%b required=1234/0", mdr, fault); end
`endif
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_back_to_back();
    test_priority();
    test_branch();
    test_reset_mid();
    test_fault();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "bench did not complete");
  end

endmodule
